axi_mem_port: RTL and testbench

- AXI4 slave front-end that converts AXI4 read and write bursts into a single-ported, always-granted synchronous SRAM request interface.
- Sits directly downstream of the core's AXI4 instruction or data master, as one instance per port.
- Feeds the behavioural RAM array in the AXI memory subsystem.
- Handles one transaction at a time; no outstanding-transaction reordering.

---
 rtl/axi_mem_port_if.sv | 64 ++++++
 rtl/axi_mem_port.sv | 179 +++++++++++++++++
 tb/tb_axi_mem_port.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_port_if.sv
// axi_mem_port_if: AXI4 AW/W/B/AR/R channel bundle for the memory port
// slave modport faces the memory port; master modport faces the AXI requester
interface axi_mem_port_if #(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH    = 32,
   parameter int AXI4_ID_WIDTH      = 16,
   parameter int AXI4_USER_WIDTH    = 10
);
   logic [AXI4_ID_WIDTH-1:0]      aw_id;
   logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr;
   logic [7:0]                    aw_len;
   logic [2:0]                    aw_size;
   logic [1:0]                    aw_burst;
   logic                          aw_valid;
   logic                          aw_ready;
   logic [AXI4_DATA_WIDTH-1:0]    w_data;
   logic [AXI4_DATA_WIDTH/8-1:0]  w_strb;
   logic                          w_last;
   logic                          w_valid;
   logic                          w_ready;
   logic [AXI4_ID_WIDTH-1:0]      b_id;
   logic [1:0]                    b_resp;
   logic [AXI4_USER_WIDTH-1:0]    b_user;
   logic                          b_valid;
   logic                          b_ready;
   logic [AXI4_ID_WIDTH-1:0]      ar_id;
   logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr;
   logic [7:0]                    ar_len;
   logic [2:0]                    ar_size;
   logic [1:0]                    ar_burst;
   logic                          ar_valid;
   logic                          ar_ready;
   logic [AXI4_ID_WIDTH-1:0]      r_id;
   logic [AXI4_DATA_WIDTH-1:0]    r_data;
   logic [1:0]                    r_resp;
   logic                          r_last;
   logic [AXI4_USER_WIDTH-1:0]    r_user;
   logic                          r_valid;
   logic                          r_ready;
   modport slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );
   modport master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );
endinterface

// File: rtl/axi_mem_port.sv
// axi_mem_port: AXI4 slave that turns read/write bursts into always-granted SRAM requests
// clk_i, rst_ni : clock and asynchronous active-low reset
// axi           : AXI4 AW/W/B/AR/R channels (slave side)
// mem_*_o       : SRAM request, write enable, word address, byte enables, write data
// mem_rdata_i   : SRAM read data, valid the cycle after a read request
module axi_mem_port #(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH    = 32,
   parameter int AXI4_ID_WIDTH      = 16,
   parameter int AXI4_USER_WIDTH    = 10,
   parameter int MEM_ADDR_WIDTH     = 22
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   axi_mem_port_if.slave              axi,
   output logic                       mem_req_o,
   output logic                       mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o,
   output logic [3:0]                 mem_be_o,
   output logic [AXI4_DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [AXI4_DATA_WIDTH-1:0] mem_rdata_i
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, WRESP} state_e;
   state_e                          state_q, state_d;
   logic [AXI4_ID_WIDTH-1:0]        id_q, id_d;
   logic [AXI4_ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]                      len_q, len_d, cnt_q, cnt_d;
   logic [2:0]                      size_q, size_d;
   logic [1:0]                      burst_q, burst_d;
   logic                            err_q, err_d, lerr_q, lerr_d, rr_q, rr_d;
   logic                            pend_q, pend_d, rvalid_q, rvalid_d;
   logic [AXI4_DATA_WIDTH-1:0]      rdata_q, rdata_d;
   logic [AXI4_ADDRESS_WIDTH-1:0]   step, wmask, incr, nxt;
   logic                            grant_r, hs_r, last, issue;
   logic [AXI4_ID_WIDTH-1:0]        sel_id;
   logic [AXI4_ADDRESS_WIDTH-1:0]   sel_addr;
   logic [7:0]                      sel_len;
   logic [2:0]                      sel_size;
   logic [1:0]                      sel_burst;
   assign mem_addr_o = {addr_q[MEM_ADDR_WIDTH-1:2], 2'b00};
   always_comb begin
      state_d = state_q;
      id_d = id_q;
      addr_d = addr_q;
      len_d = len_q;
      cnt_d = cnt_q;
      size_d = size_q;
      burst_d = burst_q;
      err_d = err_q;
      lerr_d = lerr_q;
      rr_d = rr_q;
      pend_d = pend_q;
      rvalid_d = rvalid_q;
      rdata_d = rdata_q;
      axi.aw_ready = 1'b0;
      axi.ar_ready = 1'b0;
      axi.w_ready = 1'b0;
      axi.b_valid = 1'b0;
      mem_req_o = 1'b0;
      mem_we_o = 1'b0;
      mem_be_o = 4'h0;
      mem_wdata_o = '0;
      issue = 1'b0;
      step = AXI4_ADDRESS_WIDTH'(1) << size_q;
      // WRAP keeps the upper bits of the (len+1)<<size aligned window and wraps the low bits
      wmask = ((AXI4_ADDRESS_WIDTH'(len_q) + AXI4_ADDRESS_WIDTH'(1)) << size_q) - AXI4_ADDRESS_WIDTH'(1);
      incr = addr_q + step;
      nxt = burst_q == 2'b00 ? addr_q : burst_q == 2'b10 ? (addr_q & ~wmask) | (incr & wmask) : incr;
      hs_r = rvalid_q && axi.r_ready;
      last = cnt_q == len_q;
      // round-robin: read wins a tie unless the read channel was the last one granted
      grant_r = axi.ar_valid && (!axi.aw_valid || !rr_q);
      sel_id = grant_r ? axi.ar_id : axi.aw_id;
      sel_addr = grant_r ? axi.ar_addr : axi.aw_addr;
      sel_len = grant_r ? axi.ar_len : axi.aw_len;
      sel_size = grant_r ? axi.ar_size : axi.aw_size;
      sel_burst = grant_r ? axi.ar_burst : axi.aw_burst;
      case (state_q)
         IDLE: begin
            axi.ar_ready = grant_r;
            axi.aw_ready = axi.aw_valid && !grant_r;
            if (axi.ar_valid || axi.aw_valid) begin
               id_d = sel_id;
               addr_d = sel_addr;
               len_d = sel_len;
               size_d = sel_size;
               burst_d = sel_burst;
               cnt_d = 8'd0;
               lerr_d = 1'b0;
               err_d = (sel_size > 3'd2) || (sel_burst == 2'b11) ||
                       (sel_burst == 2'b10 && !(sel_len inside {8'd1, 8'd3, 8'd7, 8'd15}));
               rr_d = grant_r;
               state_d = grant_r ? READ : WRITE;
            end
         end
         READ: begin
            // one beat in flight at most: issue when the pipe is empty or the held beat leaves
            issue = (!pend_q && !rvalid_q) || (hs_r && !last);
            mem_req_o = issue && !err_q;
            mem_be_o = 4'hF;
            if (pend_q) begin
               rvalid_d = 1'b1;
               rdata_d = mem_rdata_i;
               pend_d = 1'b0;
            end
            if (hs_r) begin
               rvalid_d = 1'b0;
               cnt_d = cnt_q + 8'd1;
               state_d = last ? IDLE : READ;
            end
            if (issue) begin
               addr_d = nxt;
               pend_d = !err_q;
               rvalid_d = err_q ? 1'b1 : rvalid_d;
               rdata_d = err_q ? '0 : rdata_d;
            end
         end
         WRITE: begin
            axi.w_ready = 1'b1;
            mem_req_o = axi.w_valid && !err_q;
            mem_we_o = 1'b1;
            mem_be_o = axi.w_strb;
            mem_wdata_o = axi.w_data;
            if (axi.w_valid) begin
               cnt_d = cnt_q + 8'd1;
               addr_d = nxt;
               lerr_d = lerr_q || (axi.w_last != last);
               state_d = last ? WRESP : WRITE;
            end
         end
         WRESP: begin
            axi.b_valid = 1'b1;
            state_d = axi.b_ready ? IDLE : WRESP;
         end
      endcase
   end
   always_comb begin
      axi.b_id = id_q;
      axi.b_resp = {err_q || lerr_q, 1'b0};
      axi.b_user = AXI4_USER_WIDTH'(0);
      axi.r_id = id_q;
      axi.r_data = rdata_q;
      axi.r_resp = {err_q, 1'b0};
      axi.r_last = rvalid_q && last;
      axi.r_user = AXI4_USER_WIDTH'(0);
      axi.r_valid = rvalid_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         id_q <= '0;
         addr_q <= '0;
         len_q <= '0;
         cnt_q <= '0;
         size_q <= '0;
         burst_q <= '0;
         err_q <= 1'b0;
         lerr_q <= 1'b0;
         rr_q <= 1'b0;
         pend_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         id_q <= id_d;
         addr_q <= addr_d;
         len_q <= len_d;
         cnt_q <= cnt_d;
         size_q <= size_d;
         burst_q <= burst_d;
         err_q <= err_d;
         lerr_q <= lerr_d;
         rr_q <= rr_d;
         pend_q <= pend_d;
         rvalid_q <= rvalid_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_axi_mem_port.sv
// tb_axi_mem_port: directed self-checking bench for axi_mem_port with a behavioural SRAM
module tb_axi_mem_port;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req, mem_we;
   logic [21:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [31:0] ram [0:1023];
   logic [21:0] log_addr [$];
   logic        log_we [$];
   logic [3:0]  log_be [$];
   logic [31:0] log_data [$];
   int          cyc = 0;
   int          pass = 0;
   int          total = 0;
   axi_mem_port_if #(
      .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(16), .AXI4_USER_WIDTH(10)
   ) bus ();
   axi_mem_port #(
      .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(16),
      .AXI4_USER_WIDTH(10), .MEM_ADDR_WIDTH(22)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .axi(bus),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (mem_req) begin
         log_addr.push_back(mem_addr);
         log_we.push_back(mem_we);
         log_be.push_back(mem_be);
         log_data.push_back(mem_wdata);
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) ram[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= ram[mem_addr[11:2]];
         end
      end
   end
   task automatic clear_log();
      log_addr.delete();
      log_we.delete();
      log_be.delete();
      log_data.delete();
   endtask
   task automatic send_ar(input logic [15:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] bu, input logic [2:0] sz, output bit ok, output int c);
      bus.ar_id = id; bus.ar_addr = a; bus.ar_len = len; bus.ar_burst = bu; bus.ar_size = sz;
      bus.ar_valid = 1'b1;
      ok = 0;
      c = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.ar_ready) begin ok = 1; c = cyc; break; end
      end
      @(posedge clk); #1;
      bus.ar_valid = 1'b0;
   endtask
   task automatic send_aw(input logic [15:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] bu, input logic [2:0] sz, output bit ok);
      bus.aw_id = id; bus.aw_addr = a; bus.aw_len = len; bus.aw_burst = bu; bus.aw_size = sz;
      bus.aw_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.aw_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      bus.aw_valid = 1'b0;
   endtask
   task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l, output bit ok);
      bus.w_data = d; bus.w_strb = s; bus.w_last = l; bus.w_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.w_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      bus.w_valid = 1'b0;
   endtask
   task automatic get_r(output logic [31:0] d, output logic [1:0] rs, output logic l,
                        output logic [15:0] id, output bit ok, output int c);
      ok = 0; d = '0; rs = '0; l = 1'b0; id = '0; c = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.r_valid && bus.r_ready) begin
            d = bus.r_data; rs = bus.r_resp; l = bus.r_last; id = bus.r_id; c = cyc; ok = 1;
            break;
         end
      end
      @(posedge clk); #1;
   endtask
   task automatic get_b(output logic [1:0] rs, output logic [15:0] id, output bit ok);
      ok = 0; rs = '0; id = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.b_valid && bus.b_ready) begin rs = bus.b_resp; id = bus.b_id; ok = 1; break; end
      end
      @(posedge clk); #1;
   endtask
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({bus.ar_ready, bus.aw_ready, bus.w_ready, bus.b_valid, bus.r_valid, mem_req} !== 6'b0)
         $display("FAIL reset_hs got %b want 000000",
                  {bus.ar_ready, bus.aw_ready, bus.w_ready, bus.b_valid, bus.r_valid, mem_req});
      else pass++;
      total++;
      if ({bus.r_last, bus.r_resp, bus.r_data, bus.b_resp, bus.r_user, bus.b_user, mem_we, mem_addr, mem_be} !== '0)
         $display("FAIL reset_out got nonzero r_data=%h mem_addr=%h b_resp=%b", bus.r_data, mem_addr, bus.b_resp);
      else pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask
   task automatic test_read_incr();
      bit ok;
      int hs, c;
      logic [31:0] d;
      logic [1:0] rs;
      logic l;
      logic [15:0] id;
      clear_log();
      send_ar(16'd5, 32'h100, 8'd3, 2'b01, 3'd2, ok, hs);
      total++; if (!ok) $display("FAIL rd_ar_hs got none want handshake"); else pass++;
      for (int k = 0; k < 4; k++) begin
         get_r(d, rs, l, id, ok, c);
         total++;
         if ({ok, d, rs, l, id} !== {1'b1, 32'hD00D0040 + 32'(k), 2'b00, k == 3, 16'd5})
            $display("FAIL rd_beat%0d got ok=%0b d=%h resp=%b last=%b id=%0d want d=%h resp=00 last=%0b id=5",
                     k, ok, d, rs, l, id, 32'hD00D0040 + 32'(k), k == 3);
         else pass++;
         if (k == 0) begin
            total++; if (c !== hs + 3) $display("FAIL rd_latency got %0d want 3", c - hs); else pass++;
         end
      end
      total++; if (log_addr.size() !== 4) $display("FAIL rd_nreq got %0d want 4", log_addr.size()); else pass++;
      for (int k = 0; k < 4; k++) begin
         total++;
         if ({log_addr[k], log_we[k], log_be[k]} !== {22'h100 + 22'(4 * k), 1'b0, 4'hF})
            $display("FAIL rd_req%0d got addr=%h we=%b be=%h want addr=%h we=0 be=f",
                     k, log_addr[k], log_we[k], log_be[k], 22'h100 + 22'(4 * k));
         else pass++;
      end
   endtask
   task automatic test_write_wrap();
      bit ok;
      logic [1:0] rs;
      logic [15:0] id;
      logic [21:0] exp_a [4] = '{22'h38, 22'h3C, 22'h30, 22'h34};
      clear_log();
      send_aw(16'd7, 32'h38, 8'd3, 2'b10, 3'd2, ok);
      total++; if (!ok) $display("FAIL wr_aw_hs got none want handshake"); else pass++;
      for (int k = 0; k < 4; k++) send_w(32'h11110000 + 32'(k), 4'hF, k == 3, ok);
      get_b(rs, id, ok);
      total++;
      if ({ok, rs, id} !== {1'b1, 2'b00, 16'd7})
         $display("FAIL wr_b got ok=%0b resp=%b id=%0d want resp=00 id=7", ok, rs, id);
      else pass++;
      total++; if (log_addr.size() !== 4) $display("FAIL wr_nreq got %0d want 4", log_addr.size()); else pass++;
      for (int k = 0; k < 4; k++) begin
         total++;
         if ({log_addr[k], log_we[k], log_be[k], log_data[k]} !== {exp_a[k], 1'b1, 4'hF, 32'h11110000 + 32'(k)})
            $display("FAIL wr_req%0d got addr=%h we=%b data=%h want addr=%h we=1 data=%h",
                     k, log_addr[k], log_we[k], log_data[k], exp_a[k], 32'h11110000 + 32'(k));
         else pass++;
      end
      total++; if (ram[12] !== 32'h11110002) $display("FAIL wr_ram got %h want 11110002", ram[12]); else pass++;
   endtask
   task automatic test_round_robin();
      bit ok;
      int c;
      logic [31:0] d;
      logic [1:0] rs;
      logic l;
      logic [15:0] id;
      bus.ar_id = 16'd1; bus.ar_addr = 32'h200; bus.ar_len = 8'd0; bus.ar_burst = 2'b01; bus.ar_size = 3'd2;
      bus.aw_id = 16'd2; bus.aw_addr = 32'h40; bus.aw_len = 8'd0; bus.aw_burst = 2'b01; bus.aw_size = 3'd2;
      bus.ar_valid = 1'b1;
      bus.aw_valid = 1'b1;
      @(negedge clk);
      total++;
      if ({bus.ar_ready, bus.aw_ready} !== 2'b10)
         $display("FAIL rr_first got ar/aw ready=%b want 10", {bus.ar_ready, bus.aw_ready});
      else pass++;
      @(posedge clk); #1;
      bus.ar_id = 16'd3; bus.ar_addr = 32'h204;
      get_r(d, rs, l, id, ok, c);
      total++;
      if ({ok, d, id, l} !== {1'b1, 32'hD00D0080, 16'd1, 1'b1})
         $display("FAIL rr_read1 got ok=%0b d=%h id=%0d last=%b want d=d00d0080 id=1 last=1", ok, d, id, l);
      else pass++;
      @(negedge clk);
      total++;
      if ({bus.ar_ready, bus.aw_ready} !== 2'b01)
         $display("FAIL rr_second got ar/aw ready=%b want 01", {bus.ar_ready, bus.aw_ready});
      else pass++;
      @(posedge clk); #1;
      bus.aw_valid = 1'b0;
      send_w(32'hCAFE0001, 4'hF, 1'b1, ok);
      get_b(rs, id, ok);
      total++;
      if ({ok, rs, id} !== {1'b1, 2'b00, 16'd2})
         $display("FAIL rr_write got ok=%0b resp=%b id=%0d want resp=00 id=2", ok, rs, id);
      else pass++;
      send_ar(16'd3, 32'h204, 8'd0, 2'b01, 3'd2, ok, c);
      get_r(d, rs, l, id, ok, c);
      total++;
      if ({ok, d, id} !== {1'b1, 32'hD00D0081, 16'd3})
         $display("FAIL rr_read2 got ok=%0b d=%h id=%0d want d=d00d0081 id=3", ok, d, id);
      else pass++;
   endtask
   task automatic test_errors();
      bit ok;
      int c;
      logic [31:0] d;
      logic [1:0] rs;
      logic l;
      logic [15:0] id;
      clear_log();
      send_ar(16'd9, 32'h300, 8'd1, 2'b11, 3'd2, ok, c);
      for (int k = 0; k < 2; k++) begin
         get_r(d, rs, l, id, ok, c);
         total++;
         if ({ok, d, rs, l, id} !== {1'b1, 32'h0, 2'b10, k == 1, 16'd9})
            $display("FAIL err_rd%0d got ok=%0b d=%h resp=%b last=%b id=%0d want d=0 resp=10 last=%0b id=9",
                     k, ok, d, rs, l, id, k == 1);
         else pass++;
      end
      send_aw(16'd10, 32'h80, 8'd0, 2'b01, 3'd3, ok);
      send_w(32'h00000BAD, 4'hF, 1'b1, ok);
      get_b(rs, id, ok);
      total++;
      if ({ok, rs, id} !== {1'b1, 2'b10, 16'd10})
         $display("FAIL err_wr_b got ok=%0b resp=%b id=%0d want resp=10 id=10", ok, rs, id);
      else pass++;
      total++; if (log_addr.size() !== 0) $display("FAIL err_nreq got %0d want 0", log_addr.size()); else pass++;
   endtask
   task automatic test_wlast();
      bit ok;
      logic [1:0] rs;
      logic [15:0] id;
      clear_log();
      send_aw(16'd11, 32'h90, 8'd1, 2'b01, 3'd2, ok);
      send_w(32'h55550001, 4'hF, 1'b1, ok);
      send_w(32'h55550002, 4'h3, 1'b0, ok);
      get_b(rs, id, ok);
      total++;
      if ({ok, rs, id} !== {1'b1, 2'b10, 16'd11})
         $display("FAIL wlast_b got ok=%0b resp=%b id=%0d want resp=10 id=11", ok, rs, id);
      else pass++;
      total++;
      if ({log_addr.size(), log_addr[0], log_be[0], log_addr[1], log_be[1]} !== {32'd2, 22'h90, 4'hF, 22'h94, 4'h3})
         $display("FAIL wlast_req got n=%0d a0=%h a1=%h be1=%h want n=2 a0=90 a1=94 be1=3",
                  log_addr.size(), log_addr[0], log_addr[1], log_be[1]);
      else pass++;
      total++;
      if ({ram[36], ram[37]} !== {32'h55550001, 32'hD00D0002})
         $display("FAIL wlast_ram got %h %h want 55550001 d00d0002", ram[36], ram[37]);
      else pass++;
   endtask
   task automatic test_stall_reset();
      bit ok, stable, stray;
      int c, n0;
      logic [31:0] d, d0;
      logic [1:0] rs;
      logic l;
      logic [15:0] id;
      clear_log();
      send_ar(16'd4, 32'h10, 8'd2, 2'b01, 3'd2, ok, c);
      get_r(d, rs, l, id, ok, c);
      total++; if ({ok, d} !== {1'b1, 32'hD00D0004}) $display("FAIL stall_b0 got %h want d00d0004", d); else pass++;
      bus.r_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.r_valid) break;
      end
      d0 = bus.r_data;
      n0 = log_addr.size();
      stable = 1;
      repeat (5) begin
         @(negedge clk);
         if (bus.r_data !== d0 || !bus.r_valid) stable = 0;
      end
      total++;
      if ({stable, d0} !== {1'b1, 32'hD00D0005})
         $display("FAIL stall_hold got stable=%0b d=%h want stable=1 d=d00d0005", stable, d0);
      else pass++;
      total++; if (log_addr.size() !== n0 || n0 !== 2) $display("FAIL stall_nreq got %0d->%0d want 2->2", n0, log_addr.size()); else pass++;
      @(posedge clk); #1;
      bus.r_ready = 1'b1;
      get_r(d, rs, l, id, ok, c);
      total++; if ({ok, d, l} !== {1'b1, 32'hD00D0005, 1'b0}) $display("FAIL stall_b1 got %h last=%b want d00d0005 last=0", d, l); else pass++;
      get_r(d, rs, l, id, ok, c);
      total++; if ({ok, d, l} !== {1'b1, 32'hD00D0006, 1'b1}) $display("FAIL stall_b2 got %h last=%b want d00d0006 last=1", d, l); else pass++;
      total++; if (log_addr.size() !== 3) $display("FAIL stall_total got %0d want 3", log_addr.size()); else pass++;
      send_ar(16'd6, 32'h20, 8'd3, 2'b01, 3'd2, ok, c);
      get_r(d, rs, l, id, ok, c);
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.r_valid, bus.b_valid, mem_req, bus.ar_ready, bus.aw_ready, bus.w_ready} !== 6'b0)
         $display("FAIL midrst_out got %b want 000000",
                  {bus.r_valid, bus.b_valid, mem_req, bus.ar_ready, bus.aw_ready, bus.w_ready});
      else pass++;
      repeat (3) @(posedge clk);
      #1;
      clear_log();
      rst_n = 1'b1;
      stray = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.r_valid || bus.b_valid) stray = 1;
      end
      total++;
      if ({stray, log_addr.size()} !== {1'b0, 32'd0})
         $display("FAIL midrst_stray got stray=%0b reqs=%0d want 0 0", stray, log_addr.size());
      else pass++;
   endtask
   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'hD00D0000 | 32'(i);
      bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0; bus.aw_valid = 1'b0;
      bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
      bus.b_ready = 1'b1;
      bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0; bus.ar_valid = 1'b0;
      bus.r_ready = 1'b1;
      test_reset();
      test_read_incr();
      test_write_wrap();
      test_round_robin();
      test_errors();
      test_wlast();
      test_stall_reset();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
